even_stats: RTL

EVEN_STATS -- requirements
Module: even_stats

---
 rtl/even_stats_if.sv | 35 +++
 rtl/even_stats.sv | 123 ++++++++++++
 2 files changed

// File: rtl/even_stats_if.sv
// Sample-in / window-summary-out bundle for even_stats.
// out_max_run exists only when EVEN_STATS_MAX_RUN_EN is defined.
interface even_stats_if;
  logic       in_valid;
  logic [7:0] in_num;
  logic       in_even;
  logic       in_ready;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_even_cnt;
  logic [7:0] out_odd_cnt;
  logic [15:0] out_even_sum;
  logic       out_err;
`ifdef EVEN_STATS_MAX_RUN_EN
  logic [7:0] out_max_run;
`endif

  // Producer of samples and consumer of summaries.
  modport master (
    output in_valid, in_num, in_even, flush, out_ready,
    input  in_ready, out_valid, out_even_cnt, out_odd_cnt, out_even_sum, out_err
`ifdef EVEN_STATS_MAX_RUN_EN
    , input out_max_run
`endif
  );

  modport slave (
    input  in_valid, in_num, in_even, flush, out_ready,
    output in_ready, out_valid, out_even_cnt, out_odd_cnt, out_even_sum, out_err
`ifdef EVEN_STATS_MAX_RUN_EN
    , output out_max_run
`endif
  );
endinterface

// File: rtl/even_stats.sv
// Per-window parity statistics; optional longest-even-run tracking under EVEN_STATS_MAX_RUN_EN.
// Latency: summary valid the cycle after the closing sample or flush.
// Backpressure: in_ready low while a summary is held; no bypass on the handshake.
module even_stats #(
  parameter int WINDOW = 16
) (
  input logic        clk,
  input logic        reset,
  even_stats_if.slave bus
);

  generate
    if (WINDOW < 2 || WINDOW > 255) begin : g_bad_window
      $error("even_stats: WINDOW must be in 2..255");
    end
  endgenerate

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  typedef struct packed {
    logic [7:0]  even_cnt;
    logic [7:0]  odd_cnt;
    logic [15:0] even_sum;
    logic        err;
`ifdef EVEN_STATS_MAX_RUN_EN
    logic [7:0]  max_run;
`endif
  } stats_t;

  state_t state_q, state_d;
  stats_t acc_q, acc_d;
  stats_t out_q;
  logic   rdy, vld;
  logic   take, close, hs;
  logic [8:0] total;
`ifdef EVEN_STATS_MAX_RUN_EN
  logic [7:0] run_q, run_d;
`endif

  assign take  = bus.in_valid && (state_q == ACCUM);
  assign total = {1'b0, acc_d.even_cnt} + {1'b0, acc_d.odd_cnt};
  // Same-edge sample counts toward both the window size and the flush guard.
  assign close = (state_q == ACCUM) &&
                 ((total == 9'(WINDOW)) || (bus.flush && (total != 9'd0)));
  assign hs    = (state_q == HOLD) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rdy     = 1'b0;
    vld     = 1'b0;
    case (state_q)
      ACCUM: begin
        rdy = 1'b1;
        if (close) state_d = HOLD;
      end
      HOLD: begin
        vld = 1'b1;
        if (bus.out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
`ifdef EVEN_STATS_MAX_RUN_EN
    run_d = run_q;
`endif
    if (take) begin
      if (bus.in_even) begin
        acc_d.even_cnt = acc_q.even_cnt + 8'd1;
        acc_d.even_sum = acc_q.even_sum + {8'd0, bus.in_num};
      end else begin
        acc_d.odd_cnt = acc_q.odd_cnt + 8'd1;
      end
      // Verdict disagrees with the LSB: even claimed for odd value or vice versa.
      if (bus.in_even == bus.in_num[0]) acc_d.err = 1'b1;
`ifdef EVEN_STATS_MAX_RUN_EN
      run_d = bus.in_even ? run_q + 8'd1 : 8'd0;
      if (run_d > acc_q.max_run) acc_d.max_run = run_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      out_q <= '0;
`ifdef EVEN_STATS_MAX_RUN_EN
      run_q <= 8'd0;
`endif
    end else begin
      if (hs) begin
        acc_q <= '0;
      end else begin
        acc_q <= acc_d;
      end
`ifdef EVEN_STATS_MAX_RUN_EN
      run_q <= hs ? 8'd0 : run_d;
`endif
      if (close) out_q <= acc_d;
    end
  end

  assign bus.in_ready     = rdy;
  assign bus.out_valid    = vld;
  assign bus.out_even_cnt = out_q.even_cnt;
  assign bus.out_odd_cnt  = out_q.odd_cnt;
  assign bus.out_even_sum = out_q.even_sum;
  assign bus.out_err      = out_q.err;
`ifdef EVEN_STATS_MAX_RUN_EN
  assign bus.out_max_run  = out_q.max_run;
`endif

endmodule
